// File: rtl/int_controller_pkg.sv
// Shared constants and types for the interrupt controller: register offsets,
// FSM state encoding and the default vector base.
package int_controller_pkg;

    localparam logic [2:0] OFF_PEND   = 3'd0;
    localparam logic [2:0] OFF_MASK   = 3'd1;
    localparam logic [2:0] OFF_MODE   = 3'd2;
    localparam logic [2:0] OFF_VECTOR = 3'd3;
    localparam logic [2:0] OFF_EOI    = 3'd4;

    localparam int VEC_BASE_DEF = 2;
    localparam int HW_W         = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVICE = 2'd2
    } state_t;

    function automatic logic [HW_W-1:0] id_to_onehot(input logic [2:0] id);
        return HW_W'(1) << id;
    endfunction

endpackage

// File: rtl/int_controller_if.sv
// MMIO bridge port of the interrupt controller: select, write strobe, word offset,
// write data and combinational read data.
interface int_controller_if;
    logic        sel;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, output we, output addr, output wdata, input rdata);
    modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/int_controller_prio_enc.sv
// Lowest-index-wins priority encoder over the masked request vector.
// Latency: combinational. Backpressure: none.
// Index 0 is the highest priority source.
module int_controller_prio_enc #(
    parameter int N = 6
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [2:0]   idx
);

    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        // Scan downward so the lowest set index is the last one assigned.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/int_controller.sv
// Programmable interrupt controller: level/edge capture, mask, fixed priority, claim/EOI.
// Latency: irq edge at t -> pend at t+1 -> HWInt at t+2; rdata combinational.
// Backpressure: none; the bridge is always accepted in one cycle.
module int_controller
    import int_controller_pkg::*;
#(
    parameter int N_SRC    = 6,
    parameter int VEC_BASE = VEC_BASE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  dev_irq,
    int_controller_if.slave   bus,
    output logic [HW_W-1:0]   HWInt,
    output logic              in_service
);

    localparam logic [31:0] VEC_OFS = 32'(VEC_BASE);

    logic [N_SRC-1:0] pend, mask, mode, prev;
    logic [N_SRC-1:0] pend_nxt, cand;
    logic [2:0]       cur_id, cur_id_nxt, win_id;
    logic             win_vld;
    state_t           state, state_nxt;

    logic rd_vec, wr_pend, wr_mask, wr_mode, wr_eoi, claim;
    logic unused_wdata_hi;

    assign rd_vec  = bus.sel & ~bus.we & (bus.addr == OFF_VECTOR);
    assign wr_pend = bus.sel &  bus.we & (bus.addr == OFF_PEND);
    assign wr_mask = bus.sel &  bus.we & (bus.addr == OFF_MASK);
    assign wr_mode = bus.sel &  bus.we & (bus.addr == OFF_MODE);
    assign wr_eoi  = bus.sel &  bus.we & (bus.addr == OFF_EOI);
    assign claim   = rd_vec & (state == PENDING);

    assign unused_wdata_hi = ^bus.wdata[31:N_SRC];

    // Edge sources: a new rising edge beats a W1C or claim clear in the same cycle.
    always_comb begin
        pend_nxt = pend;
        for (int i = 0; i < N_SRC; i++) begin
            if (mode[i]) begin
                pend_nxt[i] = (dev_irq[i] & ~prev[i]) |
                              (pend[i] & ~((wr_pend & bus.wdata[i]) |
                                           (claim & (cur_id == 3'(i)))));
            end else begin
                pend_nxt[i] = dev_irq[i];
            end
        end
    end

    assign cand = pend & mask;

    int_controller_prio_enc #(.N(N_SRC)) u_prio (
        .req   (cand),
        .valid (win_vld),
        .idx   (win_id)
    );

    // A claim takes the FSM to SERVICE even if the candidate vanished that same
    // cycle: the handler already holds a vector and will issue an EOI.
    always_comb begin
        state_nxt  = state;
        cur_id_nxt = cur_id;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt  = PENDING;
                    cur_id_nxt = win_id;
                end
            end
            PENDING: begin
                if (claim) begin
                    state_nxt = SERVICE;
                end else if (!win_vld) begin
                    state_nxt = IDLE;
                end else begin
                    cur_id_nxt = win_id;
                end
            end
            SERVICE: begin
                if (wr_eoi) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= '0;
            mask <= '0;
            mode <= '0;
            prev <= '0;
        end else begin
            pend <= pend_nxt;
            prev <= dev_irq;
            if (wr_mask) mask <= bus.wdata[N_SRC-1:0];
            if (wr_mode) mode <= bus.wdata[N_SRC-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cur_id     <= '0;
            HWInt      <= '0;
            in_service <= 1'b0;
        end else begin
            state      <= state_nxt;
            cur_id     <= cur_id_nxt;
            HWInt      <= (state_nxt == PENDING) ? id_to_onehot(cur_id_nxt) : '0;
            in_service <= (state_nxt == SERVICE);
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.sel) begin
            case (bus.addr)
                OFF_PEND:   bus.rdata = {{(32-N_SRC){1'b0}}, pend};
                OFF_MASK:   bus.rdata = {{(32-N_SRC){1'b0}}, mask};
                OFF_MODE:   bus.rdata = {{(32-N_SRC){1'b0}}, mode};
                OFF_VECTOR: if (state == PENDING) bus.rdata = {29'd0, cur_id} + VEC_OFS;
                default:    bus.rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_int_controller.sv
// Directed scenario tasks plus a randomized run against a cycle-level reference model.
module tb_int_controller;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] dev_irq = '0;
    wire  [5:0] HWInt;
    wire        in_service;

    int checks = 0;
    int errors = 0;

    int_controller_if bus_if ();

    int_controller #(.N_SRC(6), .VEC_BASE(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .dev_irq    (dev_irq),
        .bus        (bus_if.slave),
        .HWInt      (HWInt),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    // Reference model: 0 = waiting, 1 = request raised, 2 = handler running.
    bit [5:0] m_pend, m_mask, m_mode, m_prev, m_hw;
    int       m_st, m_id;
    bit       m_isvc;

    function automatic void model_reset();
        m_pend = '0; m_mask = '0; m_mode = '0; m_prev = '0; m_hw = '0;
        m_st = 0; m_id = 0; m_isvc = 1'b0;
    endfunction

    function automatic void model_step();
        bit       claim, wr, clr;
        bit [5:0] np, cand;
        int       win;
        wr    = bus_if.sel && bus_if.we;
        claim = (m_st == 1) && bus_if.sel && !bus_if.we && (bus_if.addr == 3);
        for (int i = 0; i < 6; i++) begin
            clr = (wr && bus_if.addr == 0 && bus_if.wdata[i]) || (claim && m_id == i);
            if (!m_mode[i])                     np[i] = dev_irq[i];
            else if (dev_irq[i] && !m_prev[i])  np[i] = 1'b1;
            else if (clr)                       np[i] = 1'b0;
            else                                np[i] = m_pend[i];
        end
        cand = m_pend & m_mask;
        win  = -1;
        for (int i = 0; i < 6; i++) if (cand[i] && win < 0) win = i;
        if (m_st == 0) begin
            if (win >= 0) begin m_st = 1; m_id = win; end
        end else if (m_st == 1) begin
            if (claim)        m_st = 2;
            else if (win < 0) m_st = 0;
            else              m_id = win;
        end else if (wr && bus_if.addr == 4) begin
            m_st = 0;
        end
        if (wr && bus_if.addr == 1) m_mask = bus_if.wdata[5:0];
        if (wr && bus_if.addr == 2) m_mode = bus_if.wdata[5:0];
        m_prev = dev_irq;
        m_pend = np;
        m_hw   = (m_st == 1) ? (6'd1 << m_id) : 6'd0;
        m_isvc = (m_st == 2);
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (!bus_if.sel) return 32'd0;
        case (bus_if.addr)
            3'd0: return {26'd0, m_pend};
            3'd1: return {26'd0, m_mask};
            3'd2: return {26'd0, m_mode};
            3'd3: return (m_st == 1) ? 32'(m_id + 2) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else        model_step();
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_bus();
        bus_if.sel = 1'b0; bus_if.we = 1'b0; bus_if.addr = 3'd0; bus_if.wdata = 32'd0;
    endtask

    task automatic set_rd(input logic [2:0] a);
        bus_if.sel = 1'b1; bus_if.we = 1'b0; bus_if.addr = a; bus_if.wdata = 32'd0;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        bus_if.sel = 1'b1; bus_if.we = 1'b1; bus_if.addr = a; bus_if.wdata = d;
        cyc(1);
        idle_bus();
    endtask

    task automatic apply_reset();
        dev_irq = '0;
        idle_bus();
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(1);
    endtask

    task automatic test_reset();
        dev_irq = 6'h3F;
        set_rd(3'd0);
        cyc(3);
        checks++; if (HWInt !== 6'd0) begin errors++; $display("FAIL reset_hwint got=%b exp=%b", HWInt, 6'd0); end
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL reset_insvc got=%b exp=0", in_service); end
        checks++; if (bus_if.rdata !== 32'd0) begin errors++; $display("FAIL reset_pend got=%h exp=0", bus_if.rdata); end
        reset = 1'b1;
        cyc(1);
        checks++; if (bus_if.rdata !== 32'h3F) begin errors++; $display("FAIL release_pend got=%h exp=3f", bus_if.rdata); end
        cyc(2);
        checks++; if (HWInt !== 6'd0) begin errors++; $display("FAIL masked_hwint got=%b exp=0", HWInt); end
        idle_bus();
        #1;
        checks++; if (bus_if.rdata !== 32'd0) begin errors++; $display("FAIL rdata_nosel got=%h exp=0", bus_if.rdata); end
    endtask

    task automatic test_edge_claim();
        dev_irq = '0;
        cyc(2);
        bus_wr(3'd2, 32'h01);
        bus_wr(3'd1, 32'h01);
        cyc(1);
        dev_irq = 6'h01;
        cyc(1);
        dev_irq = 6'h00;
        checks++; if (HWInt !== 6'd0) begin errors++; $display("FAIL edge_t1 got=%b exp=0", HWInt); end
        cyc(1);
        checks++; if (HWInt !== 6'b000001) begin errors++; $display("FAIL edge_t2 got=%b exp=000001", HWInt); end
        set_rd(3'd3);
        #1;
        checks++; if (bus_if.rdata !== 32'd2) begin errors++; $display("FAIL edge_vector got=%h exp=2", bus_if.rdata); end
        cyc(1);
        set_rd(3'd0);
        #1;
        checks++; if (bus_if.rdata !== 32'd0) begin errors++; $display("FAIL claim_clr got=%h exp=0", bus_if.rdata); end
        checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL claim_insvc got=%b exp=1", in_service); end
        checks++; if (HWInt !== 6'd0) begin errors++; $display("FAIL claim_hwint got=%b exp=0", HWInt); end
        idle_bus();
        bus_wr(3'd4, 32'hDEADBEEF);
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL eoi_insvc got=%b exp=0", in_service); end
        cyc(2);
        checks++; if (HWInt !== 6'd0) begin errors++; $display("FAIL eoi_hwint got=%b exp=0", HWInt); end
    endtask

    task automatic test_preempt();
        apply_reset();
        bus_wr(3'd1, 32'h3F);
        dev_irq = 6'b010000;
        cyc(2);
        checks++; if (HWInt !== 6'b010000) begin errors++; $display("FAIL pre_src4 got=%b exp=010000", HWInt); end
        dev_irq = 6'b010010;
        cyc(1);
        checks++; if (HWInt !== 6'b010000) begin errors++; $display("FAIL pre_hold got=%b exp=010000", HWInt); end
        cyc(1);
        checks++; if (HWInt !== 6'b000010) begin errors++; $display("FAIL pre_src1 got=%b exp=000010", HWInt); end
        set_rd(3'd3);
        #1;
        checks++; if (bus_if.rdata !== 32'd3) begin errors++; $display("FAIL pre_vector got=%h exp=3", bus_if.rdata); end
        cyc(1);
        idle_bus();
        dev_irq = '0;
        bus_wr(3'd4, 32'd0);
        cyc(2);
        checks++; if (HWInt !== 6'd0) begin errors++; $display("FAIL pre_done got=%b exp=0", HWInt); end
    endtask

    task automatic test_edge_in_service();
        apply_reset();
        bus_wr(3'd2, 32'h04);
        bus_wr(3'd1, 32'h04);
        dev_irq = 6'b000100; cyc(1);
        dev_irq = 6'b000000; cyc(1);
        checks++; if (HWInt !== 6'b000100) begin errors++; $display("FAIL svc_first got=%b exp=000100", HWInt); end
        set_rd(3'd3);
        #1;
        checks++; if (bus_if.rdata !== 32'd4) begin errors++; $display("FAIL svc_vector got=%h exp=4", bus_if.rdata); end
        cyc(1);
        idle_bus();
        dev_irq = 6'b000100; cyc(1);
        dev_irq = 6'b000000; cyc(1);
        set_rd(3'd0);
        #1;
        checks++; if (bus_if.rdata !== 32'h04) begin errors++; $display("FAIL svc_pend got=%h exp=4", bus_if.rdata); end
        checks++; if (HWInt !== 6'd0) begin errors++; $display("FAIL svc_hwint got=%b exp=0", HWInt); end
        idle_bus();
        bus_wr(3'd4, 32'd0);
        checks++; if (HWInt !== 6'd0) begin errors++; $display("FAIL svc_eoi_t1 got=%b exp=0", HWInt); end
        cyc(1);
        checks++; if (HWInt !== 6'b000100) begin errors++; $display("FAIL svc_eoi_t2 got=%b exp=000100", HWInt); end
    endtask

    task automatic test_mask_clear();
        apply_reset();
        bus_wr(3'd1, 32'h3F);
        dev_irq = 6'b001000;
        cyc(2);
        checks++; if (HWInt !== 6'b001000) begin errors++; $display("FAIL mclr_pend got=%b exp=001000", HWInt); end
        bus_wr(3'd1, 32'h00);
        cyc(1);
        checks++; if (HWInt !== 6'd0) begin errors++; $display("FAIL mclr_idle got=%b exp=0", HWInt); end
        set_rd(3'd3);
        #1;
        checks++; if (bus_if.rdata !== 32'd0) begin errors++; $display("FAIL mclr_vector got=%h exp=0", bus_if.rdata); end
        cyc(1);
        idle_bus();
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL mclr_insvc got=%b exp=0", in_service); end
        dev_irq = '0;
    endtask

    task automatic test_w1c_race();
        apply_reset();
        bus_wr(3'd2, 32'h20);
        dev_irq = 6'b100000;
        bus_wr(3'd0, 32'h20);
        set_rd(3'd0);
        #1;
        checks++; if (bus_if.rdata !== 32'h20) begin errors++; $display("FAIL race_set got=%h exp=20", bus_if.rdata); end
        bus_wr(3'd0, 32'h20);
        set_rd(3'd0);
        #1;
        checks++; if (bus_if.rdata !== 32'h00) begin errors++; $display("FAIL w1c_clr got=%h exp=0", bus_if.rdata); end
        bus_wr(3'd4, 32'hFFFFFFFF);
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL idle_eoi got=%b exp=0", in_service); end
        checks++; if (HWInt !== 6'd0) begin errors++; $display("FAIL idle_eoi_hw got=%b exp=0", HWInt); end
        dev_irq = '0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus_wr(3'd1, 32'h3F);
        dev_irq = 6'b000001;
        cyc(2);
        checks++; if (HWInt !== 6'b000001) begin errors++; $display("FAIL ares_pre got=%b exp=000001", HWInt); end
        #2 reset = 1'b0;
        set_rd(3'd1);
        #1;
        checks++; if (HWInt !== 6'd0) begin errors++; $display("FAIL ares_hwint got=%b exp=0", HWInt); end
        checks++; if (bus_if.rdata !== 32'd0) begin errors++; $display("FAIL ares_mask got=%h exp=0", bus_if.rdata); end
        cyc(1);
        reset = 1'b1;
        dev_irq = '0;
        idle_bus();
        cyc(1);
    endtask

    task automatic test_random();
        logic [31:0] er;
        apply_reset();
        for (int it = 0; it < 800; it++) begin
            dev_irq = dev_irq ^ (6'($urandom) & 6'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                bus_if.sel   = 1'b1;
                bus_if.we    = 1'($urandom);
                bus_if.addr  = 3'($urandom_range(0, 7));
                bus_if.wdata = $urandom;
            end else begin
                idle_bus();
                bus_if.addr = 3'($urandom_range(0, 7));
            end
            #1;
            er = exp_rdata();
            checks++; if (bus_if.rdata !== er) begin errors++; $display("FAIL rand_rdata it=%0d addr=%0d got=%h exp=%h", it, bus_if.addr, bus_if.rdata, er); end
            cyc(1);
            checks++; if (HWInt !== m_hw) begin errors++; $display("FAIL rand_hwint it=%0d got=%b exp=%b", it, HWInt, m_hw); end
            checks++; if (in_service !== m_isvc) begin errors++; $display("FAIL rand_insvc it=%0d got=%b exp=%b", it, in_service, m_isvc); end
        end
        idle_bus();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout sim_time=%0t limit=200000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        idle_bus();
        test_reset();
        test_edge_claim();
        test_preempt();
        test_edge_in_service();
        test_mask_clear();
        test_w1c_race();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
